mdu_unit: RTL and testbench

MDU_UNIT -- requirements
Module: mdu_unit

---
 rtl/mdu_unit.sv | 148 ++++++++++++++
 tb/tb_mdu_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction on entry to DONE.
module mdu_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_funct,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_c
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       funct_reg;
    logic [2*W-1:0]   acc_reg;
    logic [W-1:0]     mcand_reg;
    logic             neg_reg;
    logic             rem_neg_reg;
    logic [W-1:0]     c_reg;
    logic             ready_reg;
    logic             valid_reg;

    // Operand decode at acceptance
    logic         a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0] abs_a, abs_b;

    always_comb begin
        a_signed = !(i_funct == 3'b011 || i_funct == 3'b101 || i_funct == 3'b111);
        b_signed = a_signed && (i_funct != 3'b010);
        a_neg    = a_signed && i_a[W-1];
        b_neg    = b_signed && i_b[W-1];
        abs_a    = a_neg ? -i_a : i_a;
        abs_b    = b_neg ? -i_b : i_b;
    end

    // One iteration of each algorithm; acc_reg holds {high, low} halves
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic           div_ok;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] step;

    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
        mul_next = {mul_sum, acc_reg[W-1:1]};
        div_ok   = acc_reg[2*W-1:W-1] >= {1'b0, mcand_reg};
        div_diff = acc_reg[2*W-2:W-1] - mcand_reg;
        div_next = {(div_ok ? div_diff : acc_reg[2*W-2:W-1]), acc_reg[W-2:0], div_ok};
        step     = funct_reg[2] ? div_next : mul_next;
    end

    // Final sign correction applied to the last iteration's output
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, result;

    always_comb begin
        prod_fix = neg_reg ? -step : step;
        quo_fix  = neg_reg ? -step[W-1:0] : step[W-1:0];
        rem_fix  = rem_neg_reg ? -step[2*W-1:W] : step[2*W-1:W];
        case (funct_reg)
            3'b000:                 result = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: result = prod_fix[2*W-1:W];
            3'b100, 3'b101:         result = quo_fix;
            default:                result = rem_fix;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            funct_reg   <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            neg_reg     <= 1'b0;
            rem_neg_reg <= 1'b0;
            c_reg       <= '0;
            ready_reg   <= 1'b1;
            valid_reg   <= 1'b0;
        end else if (i_flush) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        state_reg <= BUSY;
                        ready_reg <= 1'b0;
                        cnt_reg   <= '0;
                        funct_reg <= i_funct;
                        if (i_funct[2]) begin
                            acc_reg     <= {{W{1'b0}}, abs_a};
                            mcand_reg   <= abs_b;
                            // A zero divisor must yield all-ones regardless of dividend sign
                            neg_reg     <= (a_neg ^ b_neg) && (i_b != '0);
                            rem_neg_reg <= a_neg;
                        end else begin
                            acc_reg     <= {{W{1'b0}}, abs_b};
                            mcand_reg   <= abs_a;
                            neg_reg     <= a_neg ^ b_neg;
                            rem_neg_reg <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    acc_reg <= step;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(W - 1)) begin
                        state_reg <= DONE;
                        valid_reg <= 1'b1;
                        c_reg     <= result;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_reg;
    assign o_valid = valid_reg;
    assign o_c     = c_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed-vector bench for mdu_unit: table of operations with hand-computed
// results, plus backpressure, reset and flush sequences.
module tb_mdu_unit;
    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [2:0]   i_funct;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_flush;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_c;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mdu_unit #(.DATA_WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_funct (i_funct),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_c     (o_c)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } vec_t;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Wait (bounded) for o_ready, present a request for one edge, then scramble inputs
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!o_ready && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("ready_before_issue", 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_funct = f;
        i_a     = a;
        i_b     = b;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_funct = 3'($urandom);
        i_a     = $urandom;
        i_b     = $urandom;
    endtask

    // Edges after acceptance until o_valid is seen; o_valid is registered, so it
    // is sampled high by the edge following the count returned here
    task automatic wait_valid(output int k);
        k = 0;
        while (!o_valid && k < 60) begin
            @(posedge i_clk); #1;
            k++;
        end
    endtask

    initial begin
        int k;
        int seen;
        logic [31:0] held;

        vecs[0]  = '{MUL,    32'd5,        32'd3,        32'h0000000F};
        vecs[1]  = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[2]  = '{MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        vecs[3]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[4]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{DIVU,   32'd10,       32'd0,        32'hFFFFFFFF};
        vecs[7]  = '{REMU,   32'd10,       32'd0,        32'h0000000A};
        vecs[8]  = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[9]  = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[10] = '{MUL,    32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB};
        vecs[11] = '{MUL,    32'h00010000, 32'h00010000, 32'h00000000};
        vecs[12] = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000};
        vecs[13] = '{MULHU,  32'h80000000, 32'd2,        32'h00000001};
        vecs[14] = '{DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
        vecs[15] = '{REM,    32'd7,        32'hFFFFFFFE, 32'h00000001};
        vecs[16] = '{DIV,    32'hFFFFFFF8, 32'd0,        32'hFFFFFFFF};
        vecs[17] = '{REM,    32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8};

        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_funct = '0;
        i_a     = '0;
        i_b     = '0;
        i_flush = 1'b0;
        i_ready = 1'b1;

        // Asynchronous reset before any clock edge
        #2 i_rst = 1'b1;
        #1;
        chk("reset_ready", 32'(o_ready), 32'd1);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_c", o_c, 32'd0);
        @(posedge i_clk); #2;
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        foreach (vecs[i]) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_valid(k);
            $display("op funct=%0d a=0x%08h b=0x%08h c=0x%08h expect=0x%08h valid_edge=%0d",
                     vecs[i].f, vecs[i].a, vecs[i].b, o_c, vecs[i].c, k + 1);
            chk("latency", 32'(k + 1), 32'd33);
            chk("result", o_c, vecs[i].c);
            @(posedge i_clk); #1;
            chk("valid_one_cycle", 32'(o_valid), 32'd0);
        end

        // Backpressure in DONE, stray i_valid ignored, no acceptance on DONE->IDLE edge
        i_ready = 1'b0;
        issue(MUL, 32'd5, 32'd3);
        wait_valid(k);
        chk("bp_latency", 32'(k + 1), 32'd33);
        held = o_c;
        for (int c = 0; c < 5; c++) begin
            i_valid = (c == 2);
            i_a     = 32'd99;
            @(posedge i_clk); #1;
            chk("bp_valid_held", 32'(o_valid), 32'd1);
            chk("bp_c_held", o_c, 32'h0000000F);
            chk("bp_ready_low", 32'(o_ready), 32'd0);
        end
        $display("op backpressure c=0x%08h held=0x%08h", o_c, held);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_funct = DIVU;
        i_a     = 32'd100;
        i_b     = 32'd7;
        @(posedge i_clk); #1;
        chk("bp_release_valid", 32'(o_valid), 32'd0);
        chk("bp_release_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        chk("accept_after_done", 32'(o_ready), 32'd0);
        i_valid = 1'b0;
        wait_valid(k);
        chk("post_bp_result", o_c, 32'h0000000E);
        @(posedge i_clk); #1;

        // Flush has priority over i_valid in IDLE
        i_valid = 1'b1;
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        chk("flush_blocks_accept", 32'(o_ready), 32'd1);
        i_valid = 1'b0;
        i_flush = 1'b0;

        // Reset pulse in BUSY cycle 10, then immediate re-acceptance on first edge
        issue(MUL, 32'd1234, 32'd5678);
        repeat (10) @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_busy_rst_ready", 32'(o_ready), 32'd1);
        chk("mid_busy_rst_c", o_c, 32'd0);
        #1 i_rst = 1'b0;
        i_valid = 1'b1;
        i_funct = DIV;
        i_a     = 32'd1000;
        i_b     = 32'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("accept_after_rst", 32'(o_ready), 32'd0);

        // Flush in BUSY cycle 10 of the fresh request
        repeat (9) @(posedge i_clk);
        #1 i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        chk("flush_ready", 32'(o_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge i_clk); #1;
            if (o_valid) seen++;
        end
        chk("no_valid_after_abort", 32'(seen), 32'd0);

        issue(DIVU, 32'd100, 32'd7);
        wait_valid(k);
        $display("op funct=%0d a=0x%08h b=0x%08h c=0x%08h valid_edge=%0d", DIVU, 32'd100, 32'd7, o_c, k + 1);
        chk("final_latency", 32'(k + 1), 32'd33);
        chk("final_divu", o_c, 32'h0000000E);
        @(posedge i_clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
